// File: rtl/decode_dispatch_router.sv
// Routes each decoded instruction to its functional-unit port by unit code; drops illegal codes.
// Latency 1: an accepted instruction appears on its unit port the cycle after acceptance.
// Backpressure: head-of-line; a full, non-draining target port deasserts ready_o for the whole stream.
module decode_dispatch_router #(
  parameter int funcUnitCodeSize = 3,
  parameter int payloadWidth     = 268,
  parameter int countWidth       = 64,
  parameter int FXUnitId         = 0,
  parameter int FPUnitId         = 1,
  parameter int VXUnitId         = 2,
  parameter int CRUnitId         = 3,
  parameter int LSUnitId         = 4,
  parameter int BranchUnitID     = 6
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  output logic                        ready_o,
  input  logic [funcUnitCodeSize-1:0] funcUnitType_i,
  input  logic [payloadWidth-1:0]     payload_i,
  output logic                        FXvalid_o,
  output logic                        FPvalid_o,
  output logic                        VXvalid_o,
  output logic                        CRvalid_o,
  output logic                        LSvalid_o,
  output logic                        BRvalid_o,
  input  logic                        FXready_i,
  input  logic                        FPready_i,
  input  logic                        VXready_i,
  input  logic                        CRready_i,
  input  logic                        LSready_i,
  input  logic                        BRready_i,
  output logic [payloadWidth-1:0]     FXpayload_o,
  output logic [payloadWidth-1:0]     FPpayload_o,
  output logic [payloadWidth-1:0]     VXpayload_o,
  output logic [payloadWidth-1:0]     CRpayload_o,
  output logic [payloadWidth-1:0]     LSpayload_o,
  output logic [payloadWidth-1:0]     BRpayload_o,
  output logic [countWidth-1:0]       dispatchCount_o,
  output logic [countWidth-1:0]       illegalCount_o,
  output logic                        illegal_o
);

  localparam int NUM_UNITS = 6;
  // Slot order: FX, FP, VX, CR, LS, BR
  localparam int UNIT_CODE [NUM_UNITS] = '{FXUnitId, FPUnitId, VXUnitId, CRUnitId, LSUnitId, BranchUnitID};

  logic [NUM_UNITS-1:0]    valid_q;
  logic [payloadWidth-1:0] payload_q [NUM_UNITS];
  logic [NUM_UNITS-1:0]    unit_rdy;
  logic [NUM_UNITS-1:0]    load;
  logic [2:0]              slot_idx;
  logic                    legal;
  logic                    fire;
  logic [countWidth-1:0]   dispatch_cnt_q;
  logic [countWidth-1:0]   illegal_cnt_q;
  logic                    illegal_seen_q;

  assign unit_rdy = {BRready_i, LSready_i, CRready_i, VXready_i, FPready_i, FXready_i};

  // Map the incoming unit code onto a port slot; unmatched codes are illegal
  always_comb begin
    legal    = 1'b0;
    slot_idx = 3'd0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (int'(funcUnitType_i) == UNIT_CODE[k]) begin
        legal    = 1'b1;
        slot_idx = 3'(k);
      end
    end
  end

  // Accept when the target register is empty or drains this cycle; illegal codes are always consumed
  always_comb begin
    ready_o = 1'b1;
    if (legal) begin
      ready_o = !valid_q[slot_idx] || unit_rdy[slot_idx];
    end
  end

  assign fire = enable_i && ready_o;

  // One-hot load strobe for the targeted port
  always_comb begin
    load = '0;
    if (fire && legal) begin
      load[slot_idx] = 1'b1;
    end
  end

  // Per-port output register: load wins over drain, so drain+load keeps valid high with new payload
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_port
    always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
        valid_q[g]   <= 1'b0;
        payload_q[g] <= '0;
      end else if (load[g]) begin
        valid_q[g]   <= 1'b1;
        payload_q[g] <= payload_i;
      end else if (valid_q[g] && unit_rdy[g]) begin
        valid_q[g]   <= 1'b0;
      end
    end
  end

  // Dispatch/illegal counters wrap freely; illegal flag is sticky until reset
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      dispatch_cnt_q <= '0;
      illegal_cnt_q  <= '0;
      illegal_seen_q <= 1'b0;
    end else if (fire) begin
      if (legal) begin
        dispatch_cnt_q <= dispatch_cnt_q + countWidth'(1);
      end else begin
        illegal_cnt_q  <= illegal_cnt_q + countWidth'(1);
        illegal_seen_q <= 1'b1;
      end
    end
  end

  assign FXvalid_o       = valid_q[0];
  assign FPvalid_o       = valid_q[1];
  assign VXvalid_o       = valid_q[2];
  assign CRvalid_o       = valid_q[3];
  assign LSvalid_o       = valid_q[4];
  assign BRvalid_o       = valid_q[5];
  assign FXpayload_o     = payload_q[0];
  assign FPpayload_o     = payload_q[1];
  assign VXpayload_o     = payload_q[2];
  assign CRpayload_o     = payload_q[3];
  assign LSpayload_o     = payload_q[4];
  assign BRpayload_o     = payload_q[5];
  assign dispatchCount_o = dispatch_cnt_q;
  assign illegalCount_o  = illegal_cnt_q;
  assign illegal_o       = illegal_seen_q;

endmodule

// File: tb/tb_decode_dispatch_router.sv
// Scoreboarded bench for decode_dispatch_router: per-unit expected-payload queues filled at acceptance,
// drained by a monitor on every unit transfer. Counter width reduced to 4 so wrap is reachable.
module tb_decode_dispatch_router;

  localparam int PW = 268;
  localparam int CW = 4;

  localparam logic [2:0] C_FX = 3'd0, C_FP = 3'd1, C_VX = 3'd2, C_CR = 3'd3, C_LS = 3'd4, C_BR = 3'd6;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          enable_i;
  logic          ready_o;
  logic [2:0]    funcUnitType_i;
  logic [PW-1:0] payload_i;
  logic [5:0]    vld;
  logic [5:0]    rdy;
  logic [PW-1:0] pay [6];
  logic [CW-1:0] disp_cnt;
  logic [CW-1:0] ill_cnt;
  logic          illegal_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] exp_q [6][$];
  bit            hold [6];
  logic [PW-1:0] hold_pay [6];

  always #5 clock_i = ~clock_i;

  decode_dispatch_router #(.countWidth(CW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .ready_o(ready_o),
    .funcUnitType_i(funcUnitType_i), .payload_i(payload_i),
    .FXvalid_o(vld[0]), .FPvalid_o(vld[1]), .VXvalid_o(vld[2]),
    .CRvalid_o(vld[3]), .LSvalid_o(vld[4]), .BRvalid_o(vld[5]),
    .FXready_i(rdy[0]), .FPready_i(rdy[1]), .VXready_i(rdy[2]),
    .CRready_i(rdy[3]), .LSready_i(rdy[4]), .BRready_i(rdy[5]),
    .FXpayload_o(pay[0]), .FPpayload_o(pay[1]), .VXpayload_o(pay[2]),
    .CRpayload_o(pay[3]), .LSpayload_o(pay[4]), .BRpayload_o(pay[5]),
    .dispatchCount_o(disp_cnt), .illegalCount_o(ill_cnt), .illegal_o(illegal_o)
  );

  function automatic logic [PW-1:0] mk(input int n);
    logic [31:0] w;
    w = 32'(n) * 32'h9E37_79B1;
    return {12'(n), {8{w}}};
  endfunction

  function automatic int slot_of(input logic [2:0] c);
    case (c)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: return int'(c);
      3'd6:                         return 5;
      default:                      return -1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Present one instruction and hold it until accepted (bounded)
  task automatic send(input logic [2:0] code, input logic [PW-1:0] p);
    bit done;
    int s;
    done = 1'b0;
    enable_i = 1'b1;
    funcUnitType_i = code;
    payload_i = p;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock_i);
      if (ready_o) begin
        done = 1'b1;
        s = slot_of(code);
        if (s >= 0) exp_q[s].push_back(p);
      end
      @(posedge clock_i); #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: code %0d never accepted", code);
    end
  endtask

  task automatic idle(input int n);
    enable_i = 1'b0;
    repeat (n) begin @(posedge clock_i); #1; end
  endtask

  // Monitor: every unit transfer pops and compares; held outputs must stay stable
  always @(negedge clock_i) begin
    if (!reset_i) begin
      for (int k = 0; k < 6; k++) hold[k] = 1'b0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (vld[k]) begin
          if (hold[k]) chk($sformatf("stable_u%0d", k), pay[k], hold_pay[k]);
          if (rdy[k]) begin
            if (exp_q[k].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_u%0d: got %0h expected nothing", k, pay[k]);
            end else begin
              chk($sformatf("payload_u%0d", k), pay[k], exp_q[k].pop_front());
            end
            hold[k] = 1'b0;
          end else begin
            hold[k] = 1'b1;
            hold_pay[k] = pay[k];
          end
        end else begin
          hold[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    reset_i = 1'b0;
    enable_i = 1'b1;
    funcUnitType_i = C_FX;
    payload_i = mk(1);
    rdy = 6'h3F;

    // Reset held low with enable high: nothing may load
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    chk("rst_valid", PW'(vld), '0);
    chk("rst_payload_fx", pay[0], '0);
    chk("rst_disp", PW'(disp_cnt), '0);
    chk("rst_ill", PW'(ill_cnt), '0);
    chk("rst_illflag", PW'(illegal_o), '0);
    @(posedge clock_i); #1;
    reset_i = 1'b1;

    // First FX instruction: visible one clock after acceptance
    send(C_FX, mk(1));
    chk("fx_latency1", PW'(vld[0]), PW'(1'b1));
    chk("fx_latency1_pay", pay[0], mk(1));

    // Back-to-back stream to different units
    send(C_FX, mk(2));
    send(C_LS, mk(3));
    send(C_BR, mk(4));
    send(C_FP, mk(5));
    idle(3);
    chk("disp_after_stream", PW'(disp_cnt), PW'(4'd5));

    // Head-of-line stall on a full FX port
    rdy[0] = 1'b0;
    send(C_FX, mk(6));
    fork
      begin
        send(C_FX, mk(7));
      end
      begin
        repeat (3) begin
          @(negedge clock_i);
          chk("hol_ready_low", PW'(ready_o), '0);
          chk("hol_ls_idle", PW'(vld[4]), '0);
        end
        @(posedge clock_i); #1;
        rdy[0] = 1'b1;
      end
    join
    chk("hol_b_loaded", pay[0], mk(7));
    send(C_LS, mk(8));
    idle(3);
    chk("disp_after_hol", PW'(disp_cnt), PW'(4'd8));

    // Drain and load on the same port in one cycle: no bubble
    rdy[0] = 1'b0;
    send(C_FX, mk(9));
    rdy[0] = 1'b1;
    send(C_FX, mk(10));
    chk("nobubble_valid", PW'(vld[0]), PW'(1'b1));
    chk("nobubble_pay", pay[0], mk(10));
    idle(2);
    chk("disp_after_nobubble", PW'(disp_cnt), PW'(4'd10));

    // Illegal codes 5 and 7 are consumed and dropped
    send(3'd5, mk(11));
    chk("illegal5_novalid", PW'(vld), '0);
    send(3'd7, mk(12));
    idle(1);
    chk("illegal7_novalid", PW'(vld), '0);
    chk("ill_count", PW'(ill_cnt), PW'(4'd2));
    chk("ill_flag", PW'(illegal_o), PW'(1'b1));
    chk("disp_unchanged", PW'(disp_cnt), PW'(4'd10));

    // Dispatch counter wrap at 4 bits
    for (int i = 0; i < 5; i++) send(C_CR, mk(20 + i));
    idle(1);
    chk("disp_at_15", PW'(disp_cnt), PW'(4'd15));
    send(C_VX, mk(30));
    idle(2);
    chk("disp_wrap_0", PW'(disp_cnt), '0);
    chk("ill_flag_sticky", PW'(illegal_o), PW'(1'b1));

    // Reset while an instruction is held: it is discarded
    rdy[2] = 1'b0;
    send(C_VX, mk(40));
    idle(1);
    chk("held_before_rst", PW'(vld[2]), PW'(1'b1));
    reset_i = 1'b0;
    #2;
    chk("midrst_valid", PW'(vld), '0);
    chk("midrst_pay_vx", pay[2], '0);
    chk("midrst_ill_flag", PW'(illegal_o), '0);
    chk("midrst_ill_cnt", PW'(ill_cnt), '0);
    exp_q[2].delete();
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    rdy = 6'h3F;
    idle(3);
    chk("post_rst_no_pulse", PW'(vld), '0);
    chk("post_rst_disp", PW'(disp_cnt), '0);

    for (int k = 0; k < 6; k++) chk($sformatf("drained_u%0d", k), PW'(exp_q[k].size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
